vga_pixel_sink: RTL and testbench

Receiving end of the pixel-plot interface driven by drawing logic: accepts `(VGA_X, VGA_Y, VGA_COLOR, plot)` writes into a 160×120×3-bit frame buffer and scans the buffer out as a 640×480@60 Hz VGA raster (each stored pixel replicated 4×4). It sits between any `top` drawing design and the board VGA DAC pins, giving designs verified against the simulator display a hardware path to a monitor.

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_frame_buffer.sv | 38 +++
 rtl/vga_pixel_sink.sv | 125 ++++++++++++
 tb/tb_vga_pixel_sink.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and helpers for the VGA pixel sink: 640x480@60 raster
// timing, frame-buffer geometry (160x120 stored pixels, each shown 4x4),
// the per-pixel control bundle carried down the read pipeline, and the
// address / colour helper functions used by both write and read sides.
package vga_timing_pkg;

    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;   // 800
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;   // 525
    localparam int unsigned HS_START = H_VIS + H_FP;                   // 656
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;          // 751
    localparam int unsigned VS_START = V_VIS + V_FP;                   // 490
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;          // 491

    localparam int unsigned COLS        = 160;
    localparam int unsigned ROWS        = 120;
    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned FB_DEPTH    = COLS * ROWS;                 // 19200
    localparam int unsigned FB_AW       = 15;

    // Sync/blank state that travels alongside each pixel through the pipeline.
    typedef struct packed {
        logic hs;      // active-low horizontal sync
        logic vs;      // active-low vertical sync
        logic vis;     // inside visible area
        logic origin;  // raster position (0,0)
    } raster_ctl_t;

    localparam raster_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, origin: 1'b0};

    // y*160 + x built from shifts (y*128 + y*32 + x).
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

    // Each colour bit drives its whole 8-bit DAC channel fully on or off.
    function automatic logic [23:0] expand_color(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_frame_buffer.sv
// vga_frame_buffer
// Simple dual-port 19200x3 frame store. Port A is a synchronous write port;
// port B is a registered, enable-gated read port with read-first behaviour
// on an address collision. Contents are not affected by any reset.
//   clk     : clock for both ports
//   wr_en   : write strobe (port A)
//   wr_addr : write address, wr_data : 3-bit colour
//   rd_en   : read enable (port B), rd_addr : read address
//   rd_data : registered read data
module vga_frame_buffer
    import vga_timing_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [2:0]       wr_data,
    input  logic             rd_en,
    input  logic [FB_AW-1:0] rd_addr,
    output logic [2:0]       rd_data
);

    logic [2:0] mem [FB_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Separate process samples the array before the same-edge write lands,
    // which gives the read-first collision behaviour.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink
// Accepts (VGA_X, VGA_Y, VGA_COLOR, plot) pixel writes into a 160x120x3
// frame buffer and scans it out as a 640x480@60 VGA raster, each stored
// pixel replicated 4x4.
//   CLOCK_50              : 50 MHz system clock
//   reset                 : synchronous active-high reset (buffer retained)
//   VGA_X/VGA_Y/VGA_COLOR : write coordinate and {R,G,B} colour
//   plot                  : write strobe, one write per cycle
//   VGA_R/G/B             : 8-bit DAC colour, 0 when blanked
//   VGA_HS/VGA_VS         : active-low syncs
//   VGA_BLANK_N           : high in visible region
//   VGA_SYNC_N            : tied low
//   VGA_CLK               : 25 MHz pixel clock
//   frame_start           : one-cycle pulse when pins start showing pixel (0,0)
module vga_pixel_sink
    import vga_timing_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] VGA_X,
    input  logic [6:0] VGA_Y,
    input  logic [2:0] VGA_COLOR,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(HS_START);
    localparam logic [9:0] HS_LAST  = 10'(HS_END);
    localparam logic [9:0] VS_FIRST = 10'(VS_START);
    localparam logic [9:0] VS_LAST  = 10'(VS_END);

    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    raster_ctl_t      ctl0;
    raster_ctl_t      ctl1;
    raster_ctl_t      ctl2;
    logic [FB_AW-1:0] rd_addr;
    logic [2:0]       rd_data;
    logic             wr_en;
    logic [FB_AW-1:0] wr_addr;
    logic [7:0]       rd_x;
    logic [6:0]       rd_y;

    // Range check keeps out-of-range coordinates from aliasing into the next row.
    assign wr_en   = plot && !reset && (VGA_X < 8'(COLS)) && (VGA_Y < 7'(ROWS));
    assign wr_addr = fb_addr(VGA_X, VGA_Y);

    assign rd_x = h_cnt[SCALE_SHIFT +: 8];
    assign rd_y = v_cnt[SCALE_SHIFT +: 7];

    assign VGA_SYNC_N = 1'b0;

    always_comb begin
        ctl0        = CTL_IDLE;
        ctl0.hs     = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        ctl0.vs     = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
        ctl0.vis    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        ctl0.origin = (h_cnt == '0) && (v_cnt == '0);
    end

    vga_frame_buffer u_fb (
        .clk     (CLOCK_50),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (VGA_COLOR),
        .rd_en   (pix_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Three pix_en stages: S1 address + ctl, S2 RAM data + ctl, S3 pins.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pix_en      <= 1'b0;
            VGA_CLK     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            ctl1        <= CTL_IDLE;
            ctl2        <= CTL_IDLE;
            rd_addr     <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            VGA_CLK     <= pix_en;
            frame_start <= 1'b0;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
                // Blanked positions read address 0 so the RAM is never indexed past its end.
                rd_addr <= ctl0.vis ? fb_addr(rd_x, rd_y) : '0;
                ctl1    <= ctl0;
                ctl2    <= ctl1;
                {VGA_R, VGA_G, VGA_B} <= ctl2.vis ? expand_color(rd_data) : '0;
                VGA_HS      <= ctl2.hs;
                VGA_VS      <= ctl2.vs;
                VGA_BLANK_N <= ctl2.vis;
                frame_start <= ctl2.origin;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// tb_vga_pixel_sink
// Directed bench for vga_pixel_sink. A free-running cycle counter (cyc)
// locates every pin sample: once frame_start is seen at cycle F, raster
// pixel (h,v) is on the pins for cycles F+2*(v*800+h) and the one after.
module tb_vga_pixel_sink;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] VGA_X    = '0;
    logic [6:0] VGA_Y    = '0;
    logic [2:0] VGA_COLOR = '0;
    logic       plot     = 1'b0;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;
    logic       frame_start;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rel;
    int unsigned fs;

    vga_pixel_sink dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .VGA_X       (VGA_X),
        .VGA_Y       (VGA_Y),
        .VGA_COLOR   (VGA_COLOR),
        .plot        (plot),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_CLK     (VGA_CLK),
        .frame_start (frame_start)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge CLOCK_50);
    endtask

    task automatic plot_one(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        VGA_X = x; VGA_Y = y; VGA_COLOR = c; plot = 1'b1;
        @(negedge CLOCK_50);
        plot = 1'b0;
    endtask

    task automatic check_px(input string tag, input int unsigned h, input int unsigned v,
                            input logic [23:0] exp);
        wait_cyc(fs + 2 * (v * 800 + h));
        check(tag, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hs"},    VGA_HS, 1);
        check({tag, "_vs"},    VGA_VS, 1);
        check({tag, "_blank"}, VGA_BLANK_N, 0);
        check({tag, "_rgb"},   {8'h0, VGA_R, VGA_G, VGA_B}, 0);
        check({tag, "_syncn"}, VGA_SYNC_N, 0);
        check({tag, "_clk"},   VGA_CLK, 0);
        check({tag, "_fs"},    frame_start, 0);
    endtask

    initial begin
        // Initial reset, then clear the locations the later checks look at.
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        plot_one(8'd0,  7'd1, 3'b000);
        plot_one(8'd4,  7'd3, 3'b000);
        plot_one(8'd6,  7'd3, 3'b000);
        plot_one(8'd7,  7'd3, 3'b000);
        plot_one(8'd10, 7'd5, 3'b001);

        // Reset for 3 cycles with a write held: that write must not land.
        reset = 1'b1;
        VGA_X = 8'd7; VGA_Y = 7'd3; VGA_COLOR = 3'b111; plot = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check_reset_state("rst1");
        reset = 1'b0;
        plot  = 1'b0;
        rel   = cyc;

        wait_cyc(rel + 1);
        check("pixclk_r1", VGA_CLK, 0);
        wait_cyc(rel + 2);
        check("pixclk_r2", VGA_CLK, 1);
        wait_cyc(rel + 3);
        check("pixclk_r3", VGA_CLK, 0);
        wait_cyc(rel + 5);
        check("fs_before", frame_start, 0);
        wait_cyc(rel + 6);
        check("fs_at6", frame_start, 1);
        fs = rel + 6;
        wait_cyc(rel + 7);
        check("fs_after", frame_start, 0);

        plot_one(8'd5,   7'd3,   3'b110);
        plot_one(8'd160, 7'd0,   3'b111);
        plot_one(8'd0,   7'd120, 3'b111);

        // Line 0 timing: blank at h=640, HS low for h 656..751, period 1600 cycles.
        wait_cyc(fs + 1279); check("blank_h639", VGA_BLANK_N, 1);
        wait_cyc(fs + 1280); check("blank_h640", VGA_BLANK_N, 0);
        wait_cyc(fs + 1311); check("hs_h655", VGA_HS, 1);
        wait_cyc(fs + 1312); check("hs_h656", VGA_HS, 0);
                             check("vs_line0", VGA_VS, 1);
        wait_cyc(fs + 1503); check("hs_h751", VGA_HS, 0);
        wait_cyc(fs + 1504); check("hs_h752", VGA_HS, 1);
        wait_cyc(fs + 1599); check("blank_h799", VGA_BLANK_N, 0);
        wait_cyc(fs + 1600); check("blank_v1h0", VGA_BLANK_N, 1);
        wait_cyc(fs + 2911); check("hs_l1_h655", VGA_HS, 1);
        wait_cyc(fs + 2912); check("hs_l1_h656", VGA_HS, 0);

        // Out-of-range writes must not alias into stored pixel (0,1).
        check_px("px_0_4", 0, 4, 24'h000000);
        check_px("px_3_7", 3, 7, 24'h000000);

        // Stored (5,3)=110 covers h 20..23, v 12..15.
        check_px("px_19_12", 19, 12, 24'h000000);
        check_px("px_20_12", 20, 12, 24'hFFFF00);
        check("blank_20_12", VGA_BLANK_N, 1);
        check_px("px_24_12", 24, 12, 24'h000000);
        check_px("px_28_12", 28, 12, 24'h000000);
        check_px("px_23_15", 23, 15, 24'hFFFF00);

        // Write (10,5) on the exact edge the RAM reads it for pixel (41,20).
        wait_cyc(fs + 2 * (20 * 800 + 41) - 3);
        VGA_X = 8'd10; VGA_Y = 7'd5; VGA_COLOR = 3'b100; plot = 1'b1;
        @(negedge CLOCK_50);
        plot = 1'b0;
        check_px("rw_40_20", 40, 20, 24'h0000FF);
        check_px("rw_41_20", 41, 20, 24'h0000FF);
        check_px("rw_42_20", 42, 20, 24'hFF0000);
        check_px("rw_40_21", 40, 21, 24'hFF0000);

        // Mid-frame reset: outputs return to reset values on the next edge.
        wait_cyc(fs + 2 * (24 * 800 + 5));
        reset = 1'b1;
        @(negedge CLOCK_50);
        check_reset_state("rst2");
        @(negedge CLOCK_50);
        reset = 1'b0;
        rel = cyc;
        while (!frame_start && cyc < rel + 20) @(negedge CLOCK_50);
        check("fs2_delay", cyc - rel, 6);
        fs = cyc;

        // Frame buffer survives reset.
        check_px("rst2_px_19_12", 19, 12, 24'h000000);
        check_px("rst2_px_20_12", 20, 12, 24'hFFFF00);
        check_px("rst2_px_23_12", 23, 12, 24'hFFFF00);
        check_px("rst2_px_24_12", 24, 12, 24'h000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
